// File: rtl/seq_divider_16b_pkg.sv
// seq_divider_16b_pkg: shared state encoding, default width and divide-by-zero fill for the divider
package seq_divider_16b_pkg;
  localparam int DEF_WIDTH = 16;
  localparam logic DBZ_FILL = 1'b1;
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIN  = 2'b10
  } state_t;
endpackage

// File: rtl/seq_divider_16b_sub_17b.sv
// sub_17b: ripple-borrow subtractor built from 1-bit full-subtractor cells
module sub_17b
  import seq_divider_16b_pkg::*;
#(
  parameter int N = DEF_WIDTH + 1
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] diff,
  output logic         borrow_out
);
  logic [N:0] br;
  assign br[0] = 1'b0;
  for (genvar i = 0; i < N; i++) begin : g_fs
    assign diff[i]  = a[i] ^ b[i] ^ br[i];
    assign br[i+1]  = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & br[i]);
  end
  assign borrow_out = br[N];
endmodule

// File: rtl/seq_divider_16b.sv
// seq_divider_16b: multi-cycle unsigned restoring divider, one quotient bit per cycle
module seq_divider_16b
  import seq_divider_16b_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);
  localparam int CW = $clog2(WIDTH);
  state_t state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d, d_q, d_d, r_q, r_d;
  logic [WIDTH-1:0] quotient_q, quotient_d, remainder_q, remainder_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic busy_q, busy_d, done_q, done_d, dbz_q, dbz_d;
  logic [WIDTH:0] r_shift, diff;
  logic borrow, take;
  // R stays below D, so its top bit is always zero and only WIDTH bits are stored
  assign r_shift = {r_q, q_q[WIDTH-1]};
  sub_17b #(.N(WIDTH + 1)) u_sub (
    .a         (r_shift),
    .b         ({1'b0, d_q}),
    .diff      (diff),
    .borrow_out(borrow)
  );
  // a set difference MSB can only accompany a borrow
  assign take = ~(borrow | diff[WIDTH]);
  always_comb begin
    state_d     = state_q;
    q_d         = q_q;
    d_d         = d_q;
    r_d         = r_q;
    cnt_d       = cnt_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    done_d      = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        if (divisor != '0) begin
          q_d     = dividend;
          d_d     = divisor;
          r_d     = '0;
          cnt_d   = '0;
          state_d = RUN;
        end else begin
          quotient_d  = {WIDTH{DBZ_FILL}};
          remainder_d = dividend;
          dbz_d       = 1'b1;
          state_d     = FIN;
        end
      end
      RUN: begin
        q_d   = {q_q[WIDTH-2:0], take};
        r_d   = take ? diff[WIDTH-1:0] : r_shift[WIDTH-1:0];
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          quotient_d  = q_d;
          remainder_d = r_d;
          dbz_d       = 1'b0;
          state_d     = FIN;
        end
      end
      FIN: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = state_d == RUN;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      q_q         <= '0;
      d_q         <= '0;
      r_q         <= '0;
      cnt_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      q_q         <= q_d;
      d_q         <= d_d;
      r_q         <= r_d;
      cnt_q       <= cnt_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end
  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;
endmodule

// File: tb/tb_seq_divider_16b.sv
// tb_seq_divider_16b: directed self-checking bench for the sequential divider
module tb_seq_divider_16b;
  logic clk, rst, start;
  logic [15:0] dividend, divisor, quotient, remainder;
  logic busy, done, div_by_zero;
  int n_chk = 0;
  int n_pass = 0;

  seq_divider_16b dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic run_div(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] eq, input logic [15:0] er, input logic edz,
                         input bit mid);
    int k = 0;
    int nbusy = 0;
    int lat = edz ? 1 : 17;
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({tag, "_done_pulse_ended"}, 32'(done), 32'(0));
    while (!done && k < 40) begin
      nbusy += int'(busy);
      if (mid && k == 4) begin
        start    = 1'b1;
        dividend = 16'd50;
        divisor  = 16'd5;
      end
      if (mid && k == 5) start = 1'b0;
      @(negedge clk);
      k++;
    end
    check({tag, "_latency"}, 32'(k), 32'(lat));
    check({tag, "_busy_cycles"}, 32'(nbusy), edz ? 32'(0) : 32'(16));
    check({tag, "_quotient"}, 32'(quotient), 32'(eq));
    check({tag, "_remainder"}, 32'(remainder), 32'(er));
    check({tag, "_dbz"}, 32'(div_by_zero), 32'(edz));
  endtask

  initial begin
    bit saw_done;
    rst = 1'b1;
    start = 1'b0;
    dividend = '0;
    divisor = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_done", 32'(done), 32'(0));
    check("rst_quotient", 32'(quotient), 32'(0));
    check("rst_remainder", 32'(remainder), 32'(0));
    check("rst_dbz", 32'(div_by_zero), 32'(0));
    rst = 1'b0;
    @(negedge clk);
    run_div("d100_7", 16'd100, 16'd7, 16'd14, 16'd2, 1'b0, 1'b0);
    run_div("dffff_1", 16'hFFFF, 16'h0001, 16'hFFFF, 16'd0, 1'b0, 1'b0);
    run_div("dffff_ffff", 16'hFFFF, 16'hFFFF, 16'd1, 16'd0, 1'b0, 1'b0);
    run_div("d3_7", 16'd3, 16'd7, 16'd0, 16'd3, 1'b0, 1'b0);
    run_div("d0_5", 16'd0, 16'd5, 16'd0, 16'd0, 1'b0, 1'b0);
    run_div("d5_0", 16'd5, 16'd0, 16'hFFFF, 16'd5, 1'b1, 1'b0);
    run_div("d1000_9", 16'd1000, 16'd9, 16'd111, 16'd1, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    check("hold_quotient", 32'(quotient), 32'd111);
    check("hold_remainder", 32'(remainder), 32'd1);
    check("hold_done", 32'(done), 32'(0));
    dividend = 16'd40000;
    divisor  = 16'd3;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    check("abort_busy_before", 32'(busy), 32'(1));
    check("abort_quotient_held", 32'(quotient), 32'd111);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", 32'(busy), 32'(0));
    check("abort_done", 32'(done), 32'(0));
    check("abort_quotient", 32'(quotient), 32'(0));
    check("abort_remainder", 32'(remainder), 32'(0));
    check("abort_dbz", 32'(div_by_zero), 32'(0));
    saw_done = 1'b0;
    repeat (20) begin
      @(negedge clk);
      saw_done |= done;
    end
    check("abort_no_done", 32'(saw_done), 32'(0));
    check("abort_idle_busy", 32'(busy), 32'(0));
    run_div("d40000_3", 16'd40000, 16'd3, 16'd13333, 16'd1, 1'b0, 1'b0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
